ext_mux_pipe: RTL

- Parametrised, registered N-channel selector with per-transfer width truncation and sign or zero extension.
- Adds a valid/ready handshake and a 2-entry skid buffer, so it can sit in a stalling datapath.
- Typical position: operand/immediate select stage feeding the ALU or the writeback bus.
- Generalises the fixed 4-input, fixed-extension registered mux to arbitrary channel count and width, with run-time extension mode.

---
 rtl/ext_mux_pkg.sv | 12 +
 rtl/ext_unit.sv | 21 ++
 rtl/ext_mux_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/ext_mux_pkg.sv
// ext_mux_pkg: shared extension-mode encoding and field widths for ext_mux_pipe
package ext_mux_pkg;
  typedef enum logic [1:0] {
    EXT_BYTE = 2'b00,
    EXT_HALF = 2'b01,
    EXT_WORD = 2'b10,
    EXT_FULL = 2'b11
  } ext_mode_t;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
endpackage

// File: rtl/ext_unit.sv
// ext_unit: combinational truncate-and-extend of one channel to DATA_W bits
import ext_mux_pkg::*;
module ext_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  ext_mode_t         mode,
  input  logic              sign,
  output logic [DATA_W-1:0] result
);
  int f;
  logic [DATA_W-1:0] mask;
  logic msb;
  always_comb begin
    f = mode == EXT_BYTE ? BYTE_W : mode == EXT_HALF ? HALF_W : mode == EXT_WORD ? WORD_W : DATA_W;
    mask = ~({DATA_W{1'b1}} << f);
    // field msb is the single bit where mask differs from mask>>1
    msb = |(data & (mask ^ (mask >> 1)));
    result = (data & mask) | (sign && mode != EXT_FULL && msb ? ~mask : '0);
  end
endmodule

// File: rtl/ext_mux_pipe.sv
// ext_mux_pipe: registered N-channel select/extend stage with valid/ready and 2-entry skid
// EXT_MUX_PIPE_ERRCNT_EN adds err_clear/err_count (saturating out-of-range select counter)
import ext_mux_pkg::*;
module ext_mux_pipe #(
  parameter int N_CH = 4,
  parameter int DATA_W = 32,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [1:0]             in_ext,
  input  logic                   in_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sel_err
`ifdef EXT_MUX_PIPE_ERRCNT_EN
  ,
  input  logic                   err_clear,
  output logic [15:0]            err_count
`endif
);
  logic [DATA_W-1:0] ch [N_CH];
  logic [DATA_W-1:0] ch_sel, ext_res, new_data, skid_data;
  logic sel_err, acc, load, skid_valid, skid_err;
  always_comb begin
    for (int k = 0; k < N_CH; k++) ch[k] = in_data[k*DATA_W +: DATA_W];
    sel_err = 32'(in_sel) >= N_CH;
    ch_sel = sel_err ? '0 : ch[in_sel];
    new_data = sel_err ? '0 : ext_res;
  end
  ext_unit #(.DATA_W(DATA_W)) u_ext (
    .data(ch_sel),
    .mode(ext_mode_t'(in_ext)),
    .sign(in_sign),
    .result(ext_res)
  );
  assign in_ready = !skid_valid;
  assign acc = in_valid && in_ready;
  assign load = !out_valid || out_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel_err <= 1'b0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_err <= 1'b0;
    end else begin
      if (load) out_valid <= skid_valid || acc;
      if (load && (skid_valid || acc)) begin
        out_data <= skid_valid ? skid_data : new_data;
        out_sel_err <= skid_valid ? skid_err : sel_err;
      end
      // acc implies an empty skid, so a draining skid never refills in the same cycle
      skid_valid <= skid_valid ? !load : acc && !load;
      if (acc && !load) begin
        skid_data <= new_data;
        skid_err <= sel_err;
      end
    end
  end
`ifdef EXT_MUX_PIPE_ERRCNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_count <= '0;
    else if (err_clear) err_count <= '0;
    else if (acc && sel_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`endif
endmodule
